// File: rtl/rc_frame_scheduler.sv
// rc_frame_scheduler: arbitrates manual and ignite drive words and emits each
// one on the active-low RC bus as a SYNC slot followed by three nibble slots.
module rc_frame_scheduler #(
  parameter int unsigned SLOT_TICKS = 5000000,
  parameter logic [3:0]  SYNC_PAT   = 4'b1001
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req_man,
  input  logic [11:0] man_word,
  input  logic        req_ign,
  input  logic [11:0] ign_word,
  output logic [3:0]  RC,
  output logic        ack_man,
  output logic        ack_ign,
  output logic        busy,
  output logic [1:0]  slot_idx,
  output logic        frame_done,
  output logic        abort
);

  localparam int TIMER_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(SLOT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, NIB0, NIB1, NIB2} state_t;
  typedef enum logic {SRC_MAN, SRC_IGN} src_t;

  state_t             state, state_next;
  src_t               src, src_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [11:0]        word, word_next;
  logic               slot_end;
  logic               take_man, take_ign;
  logic               done_next, abort_next;
  logic [3:0]         rc_next;
  logic [1:0]         slot_next;
  logic               busy_next;

  assign slot_end = (timer == LAST_TICK);

  // State, slot timer, latched word and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      src        <= SRC_MAN;
      timer      <= '0;
      word       <= '0;
      RC         <= 4'b1111;
      ack_man    <= 1'b0;
      ack_ign    <= 1'b0;
      busy       <= 1'b0;
      slot_idx   <= 2'd0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_next;
      src        <= src_next;
      timer      <= timer_next;
      word       <= word_next;
      RC         <= rc_next;
      ack_man    <= take_man;
      ack_ign    <= take_ign;
      busy       <= busy_next;
      slot_idx   <= slot_next;
      frame_done <= done_next;
      abort      <= abort_next;
    end
  end

  // Next state, arbitration at accept points, and the word/timer updates that follow.
  always_comb begin
    state_next = state;
    take_man   = 1'b0;
    take_ign   = 1'b0;
    done_next  = 1'b0;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        if (req_ign) begin
          take_ign = 1'b1;
        end else if (req_man) begin
          take_man = 1'b1;
        end
        if (req_ign || req_man) begin
          state_next = SYNC;
        end
      end
      SYNC, NIB0, NIB1: begin
        if (slot_end) begin
          if (src == SRC_MAN && req_ign) begin
            take_ign   = 1'b1;
            abort_next = 1'b1;
            state_next = SYNC;
          end else if (state == SYNC) begin
            state_next = NIB0;
          end else if (state == NIB0) begin
            state_next = NIB1;
          end else begin
            state_next = NIB2;
          end
        end
      end
      NIB2: begin
        if (slot_end) begin
          done_next = 1'b1;
          if (req_ign) begin
            take_ign = 1'b1;
          end else if (req_man) begin
            take_man = 1'b1;
          end
          state_next = (req_ign || req_man) ? SYNC : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    word_next = word;
    src_next  = src;
    if (take_ign) begin
      word_next = ign_word;
      src_next  = SRC_IGN;
    end else if (take_man) begin
      word_next = man_word;
      src_next  = SRC_MAN;
    end

    if (state == IDLE || slot_end) begin
      timer_next = '0;
    end else begin
      timer_next = timer + TIMER_W'(1);
    end
  end

  // Bus value, slot index and busy flag for the state being entered.
  always_comb begin
    rc_next   = 4'b1111;
    slot_next = 2'd0;
    busy_next = (state_next != IDLE);
    case (state_next)
      SYNC: begin
        rc_next   = SYNC_PAT;
        slot_next = 2'd0;
      end
      NIB0: begin
        rc_next   = ~word_next[3:0];
        slot_next = 2'd1;
      end
      NIB1: begin
        rc_next   = ~word_next[7:4];
        slot_next = 2'd2;
      end
      NIB2: begin
        rc_next   = ~word_next[11:8];
        slot_next = 2'd3;
      end
      default: begin
        rc_next   = 4'b1111;
        slot_next = 2'd0;
      end
    endcase
  end

endmodule
